// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to a keyboard or
// mouse over open-drain PS2CLK/PS2DATA. It inhibits the bus and issues a
// request-to-send, then shifts data on device clock edges. It checks the
// device ACK and aborts on a stalled bus. It also gates the companion
// receive port while a transfer is in progress.
module ps2_host_tx #(
  parameter logic [15:0] INHIBIT_CYCLES = 16'd4000,
  parameter logic [16:0] TIMEOUT_CYCLES = 17'd65535
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2clk_ext,
  input  logic       ps2data_ext,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] data,
  input  logic       dataload,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_enable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAITIDLE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  clk_sync_q, data_sync_q;
  logic [15:0] hist_q;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] timer_q, timer_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        fall;
  logic        clk_high;
  logic        data_s;
  logic        timed;
  logic [2:0]  nxt_idx;

  // Odd parity: the parity line level that makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // A falling edge needs 4 high samples followed by 12 low ones, so short
  // glitches on the device clock never advance the shifter.
  assign fall      = (hist_q == 16'hF000);
  assign clk_high  = (hist_q[3:0] == 4'hF);
  assign data_s    = data_sync_q[1];
  assign timed     = (state_q == S_REQ) || (state_q == S_DATA) ||
                     (state_q == S_PARITY) || (state_q == S_STOP) ||
                     (state_q == S_WAITIDLE);
  assign nxt_idx   = bitcnt_q + 3'd1;

  assign ps2clk_oe  = clk_oe_q;
  assign ps2data_oe = data_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign rx_enable  = ~busy_q;

  // Two-flop synchronizers on the asynchronous pad inputs (idle bus is high).
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2clk_ext};
      data_sync_q <= {data_sync_q[0], ps2data_ext};
    end
  end

  // Shift history of the synced clock, newest sample in bit 0.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hist_q <= 16'hFFFF;
    end else begin
      hist_q <= {hist_q[14:0], clk_sync_q[1]};
    end
  end

  // Next-state and output decode for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    bitcnt_d  = bitcnt_q;
    byte_d    = byte_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;

    if (timed) begin
      timer_d = fall ? 17'd0 : timer_q + 17'd1;
    end

    if (timed && !fall && (timer_q == TIMEOUT_CYCLES - 17'd1)) begin
      // Device stopped clocking or never released the bus: abort quietly.
      error_d   = 1'b1;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      timer_d   = 17'd0;
      state_d   = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          timer_d   = 17'd0;
          if (dataload) begin
            byte_d   = data;
            error_d  = 1'b0;
            busy_d   = 1'b1;
            cnt_d    = 16'd0;
            clk_oe_d = 1'b1;
            state_d  = S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt_q == INHIBIT_CYCLES - 16'd1) begin
            // Release clock and pull data low together: start bit / RTS.
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b1;
            timer_d   = 17'd0;
            state_d   = S_REQ;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_REQ: begin
          if (fall) begin
            data_oe_d = ~byte_q[0];
            bitcnt_d  = 3'd0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (fall) begin
            if (bitcnt_q == 3'd7) begin
              data_oe_d = ~odd_parity(byte_q);
              state_d   = S_PARITY;
            end else begin
              bitcnt_d  = nxt_idx;
              data_oe_d = ~byte_q[nxt_idx];
            end
          end
        end
        S_PARITY: begin
          if (fall) begin
            data_oe_d = 1'b0;
            state_d   = S_STOP;
          end
        end
        S_STOP: begin
          if (fall) begin
            if (!data_s) begin
              state_d = S_WAITIDLE;
            end else begin
              error_d = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        S_WAITIDLE: begin
          if (clk_high && data_s) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      endcase
    end
  end

  // Control and counter registers; reset beats a coincident dataload.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      timer_q   <= 17'd0;
      bitcnt_q  <= 3'd0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      bitcnt_q  <= bitcnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Latched command byte (data path, no reset needed).
  always_ff @(posedge clk_sys) begin
    byte_q <= byte_d;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (LED set, reset, typematic, mouse enable, etc.) to a keyboard or mouse over the same open-collector PS/2 lines watched by the receive port. It sits beside the receive port at the top level, and gates that port via rx_enable while a transfer is in progress. The pads are driven as open-drain: an output-enable of 1 pulls the line low, 0 releases it to Z.

Parameters:
INHIBIT_CYCLES, 16'd4000, clk_sys cycles PS2CLK is held low before request-to-send (≥100 µs at the target clock).
TIMEOUT_CYCLES, 17'd65535, max clk_sys cycles allowed between consecutive device PS2CLK falling edges (and for the final bus-idle wait) before abort.

Ports:
clk_sys  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
ps2clk_ext  in  1  raw PS2CLK pad input (asynchronous).
ps2data_ext  in  1  raw PS2DATA pad input (asynchronous).
ps2clk_oe  out  1  1 = drive PS2CLK low, 0 = release (Z).
ps2data_oe  out  1  1 = drive PS2DATA low, 0 = release (Z).
data  in  8  byte to send, sampled when dataload=1 in IDLE.
dataload  in  1  1-cycle start strobe.
busy  out  1  high from accepted dataload until return to IDLE.
done  out  1  1-cycle pulse on ACK-confirmed completion.
error  out  1  sticky; set on timeout or missing ACK; cleared by the next accepted dataload or by reset.
rx_enable  out  1  = ~busy; drives the receive port's enable_rcv.

Behaviour:
- Input sync: 2-flop synchronizer on each pad input.
- Falling-edge deglitch: 16-bit history of synced PS2CLK shifted every cycle. Falling edge = history == 16'hF000. Same shift register also gives clk_high = (history[3:0] == 4'hF).
- Reset values: state=IDLE, ps2clk_oe=0, ps2data_oe=0, busy=0, done=0, error=0, rx_enable=1, counters=0.
- Parity is odd: par = ~^data_latched.
- States:
  - IDLE: both oe=0. If dataload=1: latch data, error<=0, busy<=1, cnt<=0, go INHIBIT. While busy, dataload is ignored.
  - INHIBIT: ps2clk_oe=1, ps2data_oe=0. cnt counts up. At cnt==INHIBIT_CYCLES-1, go REQ with ps2data_oe<=1 and ps2clk_oe<=0 in the same cycle (start bit). Reset timer.
  - REQ: ps2data_oe=1, ps2clk_oe=0. On falling edge: drive bit0 (ps2data_oe=~bit0), bitcnt<=0, go DATA.
  - DATA: on each falling edge, shift out the next bit. After the falling edge that follows bit7 is driven, drive parity (oe=~par) and go PARITY.
  - PARITY: on falling edge, release data (stop bit, oe=0), go STOP.
  - STOP: on falling edge, sample synced PS2DATA.
    - 0 → ACK OK, go WAITIDLE.
    - 1 → error<=1, go IDLE.
  - WAITIDLE: wait for clk_high && synced PS2DATA==1. Then done<=1 for 1 cycle, busy<=0, go IDLE.
- Edge count: device falling edges consumed per byte = 1 (REQ) + 8 (DATA) + 1 (PARITY) + 1 (STOP) = 11.
- Timeout: in REQ, DATA, PARITY, STOP and WAITIDLE, a timer resets on each falling edge (and on state entry) and increments otherwise. On reaching TIMEOUT_CYCLES: error<=1, both oe<=0, go IDLE, no done pulse.
- done and error are never asserted together in the same transfer.
- Reset mid-transfer: next cycle both oe=0, state IDLE, busy=0, no done, error=0.
- dataload in the same cycle as reset: reset wins.

Test Plan:
- Send 0xF4, device model clocks at 12.5 kHz and ACKs → bits 0,0,1,0,1,1,1,1 observed at device rising edges, parity 0, stop 1. done pulses exactly 1 cycle after bus idle. busy/rx_enable toggle around the transfer. error=0.
- Send 0xED → parity bit 1 observed. Send 0x00 → parity 1. Send 0xFF → parity 1.
- Device never clocks after request-to-send → after TIMEOUT_CYCLES: error=1, both oe=0, busy=0, done never pulses. Next dataload clears error.
- Device leaves data high at ACK edge → error=1, no done, IDLE.
- 5-cycle low glitch on PS2CLK during DATA → no bit advance. Transfer completes correctly with 11 real edges.
- Reset asserted during DATA (bit 3) → next cycle both oe=0, busy=0. A new dataload of 0xFF then completes normally. A dataload pulsed while busy is ignored (sent byte unchanged).
